// File: rtl/debug_ctrl_v2.sv
// Host debug controller: decodes UART command bytes, loads instruction memory, runs/steps the CPU
// with a PC breakpoint, and streams a cycle/latch/register/memory dump back through the tx FIFO.
module debug_ctrl_v2 #(
   parameter int                 NB_DATA   = 32,
   parameter int                 NB_ADDR   = 32,
   parameter int                 N_REGS    = 32,
   parameter int                 N_MEM     = 32,
   parameter int                 N_LATCH   = 4,
   parameter logic [NB_DATA-1:0] HALT_CODE = 'h3f,
   parameter logic [7:0]         NACK      = 8'hEE,
   localparam int                NBY       = NB_DATA / 8,
   localparam int                NB_RSEL   = $clog2(N_REGS),
   localparam int                NB_LSEL   = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_empty,
   input  logic [7:0]         i_rx_data,
   output logic               o_rd_uart,
   input  logic               i_tx_full,
   output logic               o_wr_uart,
   output logic [7:0]         o_tx_data,
   input  logic               i_halt,
   input  logic [NB_ADDR-1:0] i_pc,
   output logic               o_enable,
   output logic               o_reset_mips,
   output logic               o_w_mem,
   output logic [NB_ADDR-1:0] o_addr_inst,
   output logic [NB_DATA-1:0] o_inst,
   output logic [NB_RSEL-1:0] o_reg_sel,
   input  logic [NB_DATA-1:0] i_reg_data,
   output logic [NB_ADDR-1:0] o_mem_addr,
   input  logic [NB_DATA-1:0] i_mem_data,
   output logic [NB_LSEL-1:0] o_latch_sel,
   input  logic [NB_DATA-1:0] i_latch_data
);

   localparam int N_WORDS = 1 + N_LATCH + N_REGS + N_MEM;
   localparam int NB_DIDX = $clog2(N_WORDS);
   localparam int NB_BCNT = (NBY > 1) ? $clog2(NBY) : 1;

   localparam logic [7:0] CMD_RUN  = 8'h03;
   localparam logic [7:0] CMD_LOAD = 8'h04;
   localparam logic [7:0] CMD_STEP = 8'h05;
   localparam logic [7:0] CMD_RST  = 8'h0C;
   localparam logic [7:0] CMD_BRK  = 8'h0E;

   typedef enum logic [3:0] {
      S_IDLE, S_DECODE, S_LOAD_B, S_WR_INST, S_BRK_B,
      S_RUN, S_STEP, S_DUMP_SEL, S_DUMP_B, S_RST_CPU
   } state_t;

   state_t               r_state, w_next;
   logic [NB_DATA-1:0]   r_word;
   logic [NB_BCNT-1:0]   r_bcnt;
   logic [NB_ADDR-1:0]   r_addr_inst;
   logic [NB_ADDR-1:0]   r_brk_addr;
   logic                 r_brk_valid;
   logic [NB_DATA-1:0]   r_cyc_cnt;
   logic                 r_run_first;
   logic                 r_halt_stop;
   logic [NB_DIDX-1:0]   r_didx;
   logic [NB_DATA-1:0]   r_dword;
   logic                 r_cap;
   logic                 r_nack_pend;

   logic [NB_DATA-1:0]   w_word_nxt;
   logic                 w_last_byte;
   logic                 w_last_word;
   logic                 w_run_stop;
   logic                 w_unknown;
   logic [NB_DATA-1:0]   w_dump_src;
   logic [NB_DIDX-1:0]   w_lat_off, w_reg_off, w_mem_off;

   assign w_word_nxt  = {r_word[NB_DATA-9:0], i_rx_data};
   assign w_last_byte = (r_bcnt == NB_BCNT'(NBY - 1));
   assign w_last_word = (r_didx == NB_DIDX'(N_WORDS - 1));
   // The first RUN cycle ignores the breakpoint so a run resumed at the breakpoint PC makes progress.
   assign w_run_stop  = i_halt | (r_brk_valid & (i_pc == r_brk_addr) & ~r_run_first);
   assign o_addr_inst = r_addr_inst;
   assign o_inst      = o_w_mem ? r_word : '0;

   assign w_lat_off = r_didx - NB_DIDX'(1);
   assign w_reg_off = r_didx - NB_DIDX'(1 + N_LATCH);
   assign w_mem_off = r_didx - NB_DIDX'(1 + N_LATCH + N_REGS);

   // Dump word index: 0 = cycle count, then latches, registers, memory words.
   always_comb begin
      w_dump_src  = r_cyc_cnt;
      o_latch_sel = '0;
      o_reg_sel   = '0;
      o_mem_addr  = '0;
      if (r_didx != '0 && r_didx <= NB_DIDX'(N_LATCH)) begin
         o_latch_sel = NB_LSEL'(w_lat_off);
         w_dump_src  = i_latch_data;
      end else if (r_didx > NB_DIDX'(N_LATCH) && r_didx <= NB_DIDX'(N_LATCH + N_REGS)) begin
         o_reg_sel  = NB_RSEL'(w_reg_off);
         w_dump_src = i_reg_data;
      end else if (r_didx > NB_DIDX'(N_LATCH + N_REGS)) begin
         o_mem_addr = NB_ADDR'(w_mem_off) << 2;
         w_dump_src = i_mem_data;
      end
   end

   always_comb begin
      w_next       = r_state;
      o_rd_uart    = 1'b0;
      o_wr_uart    = 1'b0;
      o_tx_data    = 8'h00;
      o_enable     = 1'b0;
      o_reset_mips = 1'b0;
      o_w_mem      = 1'b0;
      w_unknown    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_nack_pend) begin
               if (!i_tx_full) begin
                  o_wr_uart = 1'b1;
                  o_tx_data = NACK;
               end
            end else if (!i_rx_empty) begin
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            o_rd_uart = 1'b1;
            case (i_rx_data)
               CMD_LOAD: w_next = S_LOAD_B;
               CMD_BRK:  w_next = S_BRK_B;
               CMD_RUN:  w_next = S_RUN;
               CMD_STEP: w_next = S_STEP;
               CMD_RST:  w_next = S_RST_CPU;
               default: begin
                  w_unknown = 1'b1;
                  w_next    = S_IDLE;
                  if (!i_tx_full) begin
                     o_wr_uart = 1'b1;
                     o_tx_data = NACK;
                  end
               end
            endcase
         end
         S_LOAD_B: begin
            if (!i_rx_empty) begin
               o_rd_uart = 1'b1;
               if (w_last_byte) w_next = S_WR_INST;
            end
         end
         S_WR_INST: begin
            if (r_word == HALT_CODE) begin
               w_next = S_IDLE;
            end else begin
               o_w_mem = 1'b1;
               w_next  = S_LOAD_B;
            end
         end
         S_BRK_B: begin
            if (!i_rx_empty) begin
               o_rd_uart = 1'b1;
               if (w_last_byte) w_next = S_IDLE;
            end
         end
         S_RUN: begin
            o_enable = ~w_run_stop;
            if (w_run_stop) w_next = S_DUMP_SEL;
         end
         S_STEP: begin
            o_enable = ~i_halt;
            w_next   = S_DUMP_SEL;
         end
         S_DUMP_SEL: w_next = S_DUMP_B;
         S_DUMP_B: begin
            if (r_cap && !i_tx_full) begin
               o_wr_uart = 1'b1;
               o_tx_data = r_dword[NB_DATA-1 -: 8];
               if (w_last_byte) begin
                  if (!w_last_word)     w_next = S_DUMP_SEL;
                  else if (r_halt_stop) w_next = S_RST_CPU;
                  else                  w_next = S_IDLE;
               end
            end
         end
         S_RST_CPU: begin
            o_reset_mips = 1'b1;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_word      <= '0;
         r_bcnt      <= '0;
         r_addr_inst <= '0;
         r_brk_addr  <= '0;
         r_brk_valid <= 1'b0;
         r_cyc_cnt   <= '0;
         r_run_first <= 1'b0;
         r_halt_stop <= 1'b0;
         r_didx      <= '0;
         r_dword     <= '0;
         r_cap       <= 1'b0;
         r_nack_pend <= 1'b0;
      end else begin
         r_state <= w_next;

         if (o_reset_mips)  r_cyc_cnt <= '0;
         else if (o_enable) r_cyc_cnt <= r_cyc_cnt + NB_DATA'(1);

         if (r_state == S_DECODE && w_unknown && i_tx_full)
            r_nack_pend <= 1'b1;
         else if (r_state == S_IDLE && r_nack_pend && !i_tx_full)
            r_nack_pend <= 1'b0;

         case (r_state)
            S_DECODE: begin
               r_word      <= '0;
               r_bcnt      <= '0;
               r_run_first <= 1'b1;
               r_didx      <= '0;
               if (i_rx_data == CMD_LOAD) r_addr_inst <= '0;
            end
            S_LOAD_B, S_BRK_B: begin
               if (!i_rx_empty) begin
                  r_word <= w_word_nxt;
                  r_bcnt <= w_last_byte ? '0 : r_bcnt + NB_BCNT'(1);
                  if (r_state == S_BRK_B && w_last_byte) begin
                     r_brk_addr  <= w_word_nxt[NB_ADDR-1:0];
                     r_brk_valid <= ~&w_word_nxt;
                  end
               end
            end
            S_WR_INST: begin
               if (r_word != HALT_CODE) r_addr_inst <= r_addr_inst + NB_ADDR'(4);
            end
            S_RUN: begin
               r_run_first <= 1'b0;
               if (w_run_stop) r_halt_stop <= i_halt;
            end
            S_STEP: r_halt_stop <= i_halt;
            S_DUMP_SEL: begin
               r_cap  <= 1'b0;
               r_bcnt <= '0;
            end
            S_DUMP_B: begin
               if (!r_cap) begin
                  r_dword <= w_dump_src;
                  r_cap   <= 1'b1;
               end else if (!i_tx_full) begin
                  r_dword <= {r_dword[NB_DATA-9:0], 8'h00};
                  r_bcnt  <= w_last_byte ? '0 : r_bcnt + NB_BCNT'(1);
                  if (w_last_byte) r_didx <= w_last_word ? '0 : r_didx + NB_DIDX'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
